// File: rtl/updown_counter_gen.sv
// Parametrised up/down counter with programmable modulus, enable prescaler,
// parallel load, synchronous clear, wrap/saturate mode and terminal-count pulse.
module updown_counter_gen #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = (2 ** WIDTH) - 1,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_C  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]  PS_ZERO = {PS_W{1'b0}};
    localparam logic [PS_W-1:0]  PS_ONE  = {{(PS_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic [PS_W-1:0]  ps_q, ps_d;
    logic             tc_q, tc_d;
    logic             tick_s;
    logic             at_bound_s;
    logic [WIDTH-1:0] load_clamp_s;

    assign tick_s       = en & (ps_q == PS_LAST);
    // "Bound" is direction dependent: the top when counting up, zero when counting down.
    assign at_bound_s   = up ? (count_q == MAX_C) : (count_q == ZERO_C);
    assign load_clamp_s = (load_val > MAX_C) ? MAX_C : load_val;

    // Next-state: clr beats load beats a prescaled count step.
    always_comb begin
        count_d = count_q;
        ps_d    = ps_q;
        tc_d    = 1'b0;
        if (clr) begin
            count_d = ZERO_C;
            ps_d    = PS_ZERO;
        end else if (load) begin
            count_d = load_clamp_s;
            ps_d    = PS_ZERO;
        end else if (en) begin
            if (tick_s) begin
                ps_d = PS_ZERO;
                // Blocked saturate steps pulse tc exactly like wrap events.
                tc_d = at_bound_s;
                case ({up, at_bound_s})
                    2'b11:   count_d = sat ? count_q : ZERO_C;
                    2'b10:   count_d = count_q + ONE_C;
                    2'b01:   count_d = sat ? count_q : MAX_C;
                    2'b00:   count_d = count_q - ONE_C;
                    default: count_d = count_q;
                endcase
            end else begin
                ps_d = ps_q + PS_ONE;
            end
        end else begin
            count_d = count_q;
            ps_d    = ps_q;
        end
    end

    // State registers; the asynchronous reset overrides any in-flight update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= ZERO_C;
            ps_q    <= PS_ZERO;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            ps_q    <= ps_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

endmodule

// File: doc/updown_counter_gen.md
# updown_counter_gen

Parametrised synchronous up/down counter core. It adds a configurable width, a programmable modulus, an enable prescaler, parallel load, synchronous clear, wrap or saturate mode, and a terminal-count pulse. It replaces the fixed 4-bit up/down counter in TinyTapeout user designs and is instantiated inside a `tt_um_*` wrapper, which maps `ui_in`/`uio_in` to controls and `uo_out` to `count`/`tc`.

## Interface
Parameters:
- `WIDTH`, default 8: counter width in bits; legal range 2..16.
- `MAX_VAL`, default 2**WIDTH-1: top count, so the modulus is MAX_VAL+1; legal range 1..2**WIDTH-1.
- `PRESCALE`, default 1: number of enabled clocks per count step; legal range 1..256; 1 means no prescaling.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `en`  in  1  count enable; gates the prescaler.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `sat`  in  1  mode: 1 = saturate at the bounds, 0 = wrap modulo MAX_VAL+1.
- `clr`  in  1  synchronous clear of count and prescaler.
- `load`  in  1  synchronous parallel load.
- `load_val`  in  WIDTH  value to load.
- `count`  out  WIDTH  current count, registered.
- `tc`  out  1  terminal-count pulse, registered.

## Operation
- **Reset:** while rst_n is low, count = 0, tc = 0 and the prescaler = 0, immediately and independent of clk. Release is synchronous to the next clk edge.
- **Priority per edge:** clr > load > count step.
- **clr:** count ← 0 and prescaler ← 0. tc is 0 on this edge.
- **load:** count ← min(load_val, MAX_VAL) and prescaler ← 0. tc is 0 on this edge.
- **Prescaler:** counts from 0 to PRESCALE-1 on each edge with en = 1.
  - A "tick" occurs on an edge where en = 1 and prescaler = PRESCALE-1; the prescaler then returns to 0.
  - With en = 0 the prescaler holds its value and does not reset.
  - With PRESCALE = 1, every enabled edge is a tick.
- **Count step on a tick:**
  - up = 1, count < MAX_VAL: count + 1.
  - up = 1, count = MAX_VAL: 0 if sat = 0; hold if sat = 1.
  - up = 0, count > 0: count − 1.
  - up = 0, count = 0: MAX_VAL if sat = 0; hold if sat = 1.
- **tc:** set to 1 for exactly one cycle on a tick where the count is at a bound in the direction of travel (up at MAX_VAL, or down at 0). This applies in both modes: wrap events and blocked saturate steps both pulse. On every other edge tc ← 0.
- **Input changes:** up and sat may change on any cycle and take effect at the next tick. A direction change does not reset the prescaler.
- **Width rule:** all comparisons are unsigned at WIDTH bits. count never exceeds MAX_VAL.

## Timing
- Latency is 1 cycle: clr, load or a tick at edge N is visible on count after edge N, and tc is high for the cycle after edge N.
- Count rate is one step per PRESCALE enabled cycles. Continuous en gives a period of PRESCALE clocks.
- If the count keeps hitting a bound, tc pulses on consecutive ticks. With PRESCALE = 1 and sat = 1 held at a bound, tc stays high continuously (one pulse per cycle).
- Reset mid-operation: the asynchronous clear wins over any in-flight load, clr or tick. There is no residual tc after reset release.

## Test plan
All scenarios use WIDTH=4, MAX_VAL=9 unless stated otherwise.
- **Reset:** drive rst_n low mid-count (count=5) asynchronously -> count=0 and tc=0 before the next clk edge. After release, up=1 and en=1 give 1, 2, 3 on successive edges.
- **Wrap up/down** (PRESCALE=1, sat=0): from 8 count up -> 9, 0 (tc=1 with count=0), 1. Then up=0 from 1 -> 0, 9 (tc=1), 8.
- **Saturate** (sat=1): at 9 with up=1 for 3 cycles -> count holds at 9 and tc=1 each cycle. At 0 with up=0 -> count holds at 0 and tc pulses.
- **Load/clr priority:** load_val=13 with load=1 -> count=9 (clamped). load_val=4 with load=1 and clr=1 on the same edge -> count=0. load=1 together with a tick from 7 -> count=4 and tc=0.
- **Prescaler** (PRESCALE=3, up=1 from 0): en=1 for 6 edges -> count changes only on edges 3 and 6 (to 1, then 2). Dropping en for 2 cycles after edge 1 delays the first step by 2 cycles. A load at edge 2 restarts the prescaler phase.
- **Full width** (WIDTH=8, default MAX_VAL=255, sat=0): 255 up -> 0 with tc=1. 0 down -> 255 with tc=1.
